vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Generates VGA raster timing (hsinc, vsinc, draw) for the clock-display renderer downstream.
//  Runs off the pixel clock domain and counts columns and rows.
//  Exports the raster position so later stages need not re-derive it.
//  Default timing is 640x480@60 (800x525 total), which matches the renderer's 800/525 line and frame lengths.
// PARAMETERS
//  H_VISIBLE   640  active pixels per line
//  H_FRONT     16   horizontal front porch, pixels
//  H_SYNC      96   hsync pulse width, pixels
//  H_BACK      48   horizontal back porch, pixels
//  V_VISIBLE   480  active lines per frame
//  V_FRONT     10   vertical front porch, lines
//  V_SYNC      2    vsync pulse width, lines
//  V_BACK      33   vertical back porch, lines
//  SYNC_POL    0    asserted level of hsinc/vsinc (0 = active-low, standard VGA)
// PORTS
//  pixelclock   in   1   pixel-rate clock; sole clock
//  reset        in   1   synchronous, active-high reset
//  ce           in   1   pixel enable; counters advance only when 1 (tie 1 if pixelclock = pixel rate)
//  hsinc        out  1   horizontal sync, registered
//  vsinc        out  1   vertical sync, registered
//  draw         out  1   1 inside the visible area, registered
//  h_pos        out  10  current column (0..H_TOTAL-1), registered
//  v_pos        out  10  current row (0..V_TOTAL-1), registered
//  frame_start  out  1   one-cycle pulse at h=0, v=0
// BEHAVIOUR
//  - H_TOTAL = sum of H_* parameters; V_TOTAL = sum of V_* parameters. Both must be <= 1024 (10-bit counters).
//  - Internal counters hc and vc:
//    - On a ce cycle: hc increments.
//    - At hc == H_TOTAL-1, hc wraps to 0 and vc increments.
//    - At vc == V_TOTAL-1 coincident with the hc wrap, vc also wraps to 0.
//    - ce = 0: counters and all outputs hold.
//  - Outputs are decoded from the counters and registered, so they lag the counters by 1 clock.
//    - h_pos/v_pos always equal the position that draw/hsinc/vsinc describe.
//  - draw = (hc < H_VISIBLE) && (vc < V_VISIBLE).
//  - hsinc asserted (== SYNC_POL) iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC.
//  - vsinc asserted iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC.
//    - vsinc changes only in the cycle after hc wraps.
//  - Exactly one hsinc assertion per line and one vsinc assertion per frame.
//    - The downstream renderer counts one edge of each, in either polarity.
//  - frame_start = 1 for the single registered cycle where h_pos = 0 and v_pos = 0; otherwise 0.
//    - With ce gating, it is 1 for exactly one ce-qualified cycle and deasserts on the next clock.
//  - Reset (synchronous, dominates ce):
//    - hc = vc = 0; h_pos = v_pos = 0; draw = 0; frame_start = 0.
//    - hsinc = vsinc = ~SYNC_POL (deasserted).
//    - First ce cycle after reset release registers position (0,0): draw = 1, frame_start = 1.
//    - Reset mid-line or mid-sync terminates any sync pulse immediately; no partial frame is completed.
//  - No state machine beyond the two counters; every state is reachable only via wrap or reset.
// CONFIGURATION
//  - VGA_SYNC_FRAME_COUNT_EN defined:
//    - Adds output frame_cnt [7:0], reset to 0.
//    - Increments (mod 256) on each vc wrap, i.e. in the same cycle frame_start is registered.
//    - Used for blink effects on the display.
//  - Macro undefined: port and logic are absent; all other behaviour is identical.
// TESTING
//  - Reset held 3 clocks, ce = 1 -> during reset hsinc = vsinc = 1, draw = 0; first cycle after release: h_pos = 0, v_pos = 0, draw = 1, frame_start = 1.
//  - Defaults, ce = 1, run 1 line -> draw high 640 clocks, low 160; hsinc low exactly 96 clocks for h_pos 656..751; line period 800.
//  - Run 2 frames -> vsinc low for v_pos 490..491 (1600 clocks); frame period 420000 clocks; frame_start pulses once per frame.
//  - ce toggling 1,0,1,0 -> outputs hold on ce = 0 cycles; line period 1600 clocks; hsinc width 192 clocks.
//  - Assert reset at h_pos = 700, v_pos = 300 (mid-hsync) -> hsinc deasserts next clock; restart at (0,0).
//  - VGA_SYNC_FRAME_COUNT_EN, run 257 frames -> frame_cnt wraps 255 -> 0; increments coincide with frame_start.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: column/row counters with registered sync, draw and position.
// Define VGA_SYNC_FRAME_COUNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       pixelclock,
    input  logic       reset,
    input  logic       ce,
    output logic       hsinc,
    output logic       vsinc,
    output logic       draw,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos,
    output logic       frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VEND  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VEND  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [10:0] hc_x;
    logic [10:0] vc_x;
    logic        h_wrap;
    logic        v_wrap;
    logic        vis_d;
    logic        hs_on;
    logic        vs_on;
    logic        origin;

    // 11-bit views so thresholds equal to 1024 still compare correctly
    always_comb begin
        hc_x   = {1'b0, hc};
        vc_x   = {1'b0, vc};
        h_wrap = (hc == H_LAST);
        v_wrap = h_wrap && (vc == V_LAST);
        vis_d  = (hc_x < H_VEND) && (vc_x < V_VEND);
        hs_on  = (hc_x >= HS_BEG) && (hc_x < HS_END);
        vs_on  = (vc_x >= VS_BEG) && (vc_x < VS_END);
        origin = (hc == 10'd0) && (vc == 10'd0);
    end

    always_ff @(posedge pixelclock) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (ce) begin
            hc <= h_wrap ? 10'd0 : hc + 10'd1;
            if (h_wrap) begin
                vc <= v_wrap ? 10'd0 : vc + 10'd1;
            end
        end
    end

    always_ff @(posedge pixelclock) begin
        if (reset) begin
            hsinc <= ~SYNC_POL;
            vsinc <= ~SYNC_POL;
            draw  <= 1'b0;
            h_pos <= '0;
            v_pos <= '0;
        end else if (ce) begin
            hsinc <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsinc <= vs_on ? SYNC_POL : ~SYNC_POL;
            draw  <= vis_d;
            h_pos <= hc;
            v_pos <= vc;
        end
    end

    // Single-clock pulse: drops on the next clock even when ce is low
    always_ff @(posedge pixelclock) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce && origin;
        end
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic wrap_pend;

    always_ff @(posedge pixelclock) begin
        if (reset) begin
            wrap_pend <= 1'b0;
            frame_cnt <= '0;
        end else if (ce) begin
            wrap_pend <= v_wrap;
            if (wrap_pend) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
